// File: rtl/lsu_misaligned_pkg.sv
// Shared constants for the misaligned load/store unit: RV32 funct3 encodings,
// access-size codes and the legality check used at request accept.
package lsu_misaligned_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
    if (write)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: places store data/masks into the 64-bit
// two-word lane space and extracts/extends load data from {q1,q0}.
module lsu_lane_align
  import lsu_misaligned_pkg::*;
(
  input  logic [1:0]          off,
  input  logic [2:0]          funct3,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   q0,
  input  logic [DATA_W-1:0]   q1,
  output logic [7:0]          mask8,
  output logic [2*DATA_W-1:0] wdata64,
  output logic [DATA_W-1:0]   rdata
);

  function automatic logic [DATA_W-1:0] extend(input logic [2*DATA_W-1:0] lanes,
                                               input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(lanes[7:0]);
    h = $signed(lanes[15:0]);
    case (f3[1:0])
      SZ_B:    extend = f3[2] ? {24'b0, lanes[7:0]}  : DATA_W'(b);
      SZ_H:    extend = f3[2] ? {16'b0, lanes[15:0]} : DATA_W'(h);
      default: extend = lanes[DATA_W-1:0];
    endcase
  endfunction

  logic [3:0]          size_mask;
  logic [2*DATA_W-1:0] lanes;

  always_comb begin
    case (funct3[1:0])
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      default: size_mask = MASK_W;
    endcase
    mask8   = {4'b0, size_mask} << off;
    wdata64 = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
    lanes   = {q1, q0} >> {off, 3'b000};
    rdata   = extend(lanes, funct3);
  end

endmodule

// File: rtl/lsu_misaligned.sv
// RV32 load/store unit that splits word-crossing accesses into two aligned
// word transactions and returns extended load data as a one-cycle response.
module lsu_misaligned
  import lsu_misaligned_pkg::*;
#(
  parameter int WORD_ADDR_BITS = DATA_W - 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [DATA_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [2:0]                req_funct3,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_error,
  output logic [WORD_ADDR_BITS-1:0] mem_address,
  output logic [3:0]                mem_byteena,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t state;
  logic   handshake;
  logic   wren_q;

  logic              wr_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic [3:0]        mask_hi_q;
  logic [DATA_W-1:0] wdata_hi_q;
  logic [DATA_W-1:0] q0_q;

  logic [1:0]          al_off;
  logic [2:0]          al_funct3;
  logic [DATA_W-1:0]   al_q0;
  logic [DATA_W-1:0]   al_q1;
  logic [7:0]          mask8;
  logic [2*DATA_W-1:0] wdata64;
  logic [DATA_W-1:0]   rdata;

  assign req_ready = (state == IDLE) && !reset;
  assign handshake = req_valid && req_ready;
  // A write already registered for ACC1 must not commit on the reset edge.
  assign mem_wren  = wren_q && !reset;

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  // The final access word comes straight from mem_q so the response can be
  // registered on the same edge that leaves the last access state.
  always_comb begin
    al_off    = (state == IDLE) ? req_addr[1:0] : off_q;
    al_funct3 = (state == IDLE) ? req_funct3    : funct3_q;
    al_q0     = (state == ACC0) ? mem_q : q0_q;
    al_q1     = (state == ACC1) ? mem_q : '0;
  end

  lsu_lane_align u_align (
    .off     (al_off),
    .funct3  (al_funct3),
    .wdata   (req_wdata),
    .q0      (al_q0),
    .q1      (al_q1),
    .mask8   (mask8),
    .wdata64 (wdata64),
    .rdata   (rdata)
  );

  // Request latch and first-word capture
  always_ff @(posedge clock) begin
    if (handshake) begin
      wr_q       <= req_write;
      off_q      <= req_addr[1:0];
      funct3_q   <= req_funct3;
      mask_hi_q  <= mask8[7:4];
      wdata_hi_q <= wdata64[2*DATA_W-1:DATA_W];
    end
    if (state == ACC0)
      q0_q <= mem_q;
  end

  // Access sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      wren_q      <= 1'b0;
      mem_byteena <= '0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            if (funct3_legal(req_write, req_funct3)) begin
              state       <= ACC0;
              mem_address <= req_addr[WORD_ADDR_BITS+1:2];
              mem_byteena <= mask8[3:0];
              mem_data    <= wdata64[DATA_W-1:0];
              wren_q      <= req_write;
            end else begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        ACC0: begin
          if (mask_hi_q != 4'b0) begin
            state       <= ACC1;
            mem_address <= mem_address + WORD_ADDR_BITS'(1);
            mem_byteena <= mask_hi_q;
            mem_data    <= wdata_hi_q;
          end else begin
            state       <= DONE;
            mem_byteena <= '0;
            wren_q      <= 1'b0;
            resp_valid  <= 1'b1;
            resp_rdata  <= wr_q ? '0 : rdata;
          end
        end
        ACC1: begin
          state       <= DONE;
          mem_byteena <= '0;
          wren_q      <= 1'b0;
          resp_valid  <= 1'b1;
          resp_rdata  <= wr_q ? '0 : rdata;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_misaligned.sv
// Directed bench for lsu_misaligned with a small byte-enabled word memory.
module tb_lsu_misaligned;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [29:0] mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  logic [31:0] mem [16];
  int checks;
  int errors;

  lsu_misaligned dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_funct3  (req_funct3),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .mem_address (mem_address),
    .mem_byteena (mem_byteena),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_q = mem[mem_address[3:0]];

  always @(posedge clock) begin
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) mem[mem_address[3:0]][8*b +: 8] <= mem_data[8*b +: 8];
  end

  // Drives one request and returns #1 after its accept edge (cycle 1).
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    int n;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL issue_ready: req_ready=%0b required=1", req_ready);
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_funct3 = f3;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", req_ready); end
    checks++;
    if ({resp_valid, resp_error, mem_wren, mem_byteena} !== 7'b0) begin
      errors++;
      $display("FAIL rst_ctrl: got v=%0b e=%0b w=%0b be=%b want all 0", resp_valid, resp_error, mem_wren, mem_byteena);
    end
    checks++;
    if (mem_address !== 30'h0 || mem_data !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_data: got a=%h d=%h r=%h want 0", mem_address, mem_data, resp_rdata);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_store_word();
    mem[0] = 32'h0;
    issue(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
    checks++;
    if (mem_address !== 30'h40 || mem_byteena !== 4'b1111 || mem_data !== 32'hDEADBEEF || mem_wren !== 1'b1) begin
      errors++;
      $display("FAIL sw_acc0: got a=%h be=%b d=%h w=%0b want 40 1111 deadbeef 1", mem_address, mem_byteena, mem_data, mem_wren);
    end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL sw_early_resp: got %0b want 0", resp_valid); end
    next_cycle();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0 || mem_wren !== 1'b0 || mem_byteena !== 4'b0) begin
      errors++;
      $display("FAIL sw_resp: got v=%0b r=%h e=%0b w=%0b be=%b want 1 0 0 0 0", resp_valid, resp_rdata, resp_error, mem_wren, mem_byteena);
    end
    checks++;
    if (mem[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h want deadbeef", mem[0]); end
    next_cycle();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL sw_pulse: got v=%0b rdy=%0b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] addrs [3];
    logic [2:0]  f3s   [3];
    logic [31:0] exps  [3];
    addrs = '{32'h103, 32'h103, 32'h102};
    f3s   = '{3'b000, 3'b100, 3'b001};
    exps  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    mem[0] = 32'h80FF0102;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, addrs[i], 32'h0, f3s[i]);
      checks++;
      if (mem_wren !== 1'b0 || mem_address !== 30'h40) begin
        errors++;
        $display("FAIL ld_acc0_%0d: got w=%0b a=%h want 0 40", i, mem_wren, mem_address);
      end
      next_cycle();
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exps[i] || resp_error !== 1'b0) begin
        errors++;
        $display("FAIL ld_ext_%0d: got v=%0b r=%h e=%0b want 1 %h 0", i, resp_valid, resp_rdata, resp_error, exps[i]);
      end
    end
  endtask

  task automatic test_misaligned_load();
    mem[0] = 32'h33221100;
    mem[1] = 32'h77665544;
    issue(1'b0, 32'h102, 32'h0, 3'b010);
    checks++;
    if (mem_address !== 30'h40 || mem_byteena !== 4'b1100) begin
      errors++;
      $display("FAIL lw_mis_acc0: got a=%h be=%b want 40 1100", mem_address, mem_byteena);
    end
    next_cycle();
    checks++;
    if (mem_address !== 30'h41 || mem_byteena !== 4'b0011 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_mis_acc1: got a=%h be=%b v=%0b want 41 0011 0", mem_address, mem_byteena, resp_valid);
    end
    next_cycle();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h55443322) begin
      errors++;
      $display("FAIL lw_mis_resp: got v=%0b r=%h want 1 55443322", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_misaligned_store();
    mem[1] = 32'h77665544;
    mem[2] = 32'h11111111;
    issue(1'b1, 32'h107, 32'h0000ABCD, 3'b001);
    checks++;
    if (mem_address !== 30'h41 || mem_byteena !== 4'b1000 || mem_data[31:24] !== 8'hCD || mem_wren !== 1'b1) begin
      errors++;
      $display("FAIL sh_acc0: got a=%h be=%b d=%h w=%0b want 41 1000 cd.. 1", mem_address, mem_byteena, mem_data, mem_wren);
    end
    next_cycle();
    checks++;
    if (mem_address !== 30'h42 || mem_byteena !== 4'b0001 || mem_data[7:0] !== 8'hAB || mem_wren !== 1'b1) begin
      errors++;
      $display("FAIL sh_acc1: got a=%h be=%b d=%h w=%0b want 42 0001 ..ab 1", mem_address, mem_byteena, mem_data, mem_wren);
    end
    next_cycle();
    checks++;
    if (resp_valid !== 1'b1 || mem[1] !== 32'hCD665544 || mem[2] !== 32'h111111AB) begin
      errors++;
      $display("FAIL sh_mem: got v=%0b m1=%h m2=%h want 1 cd665544 111111ab", resp_valid, mem[1], mem[2]);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] wr_f3 [2];
    wr_f3 = '{4'b0011, 4'b1011};
    for (int i = 0; i < 2; i++) begin
      issue(wr_f3[i][3], 32'h100, 32'hFFFFFFFF, wr_f3[i][2:0]);
      checks++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0 ||
          mem_byteena !== 4'b0 || mem_wren !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d: got v=%0b e=%0b r=%h be=%b w=%0b want 1 1 0 0 0",
                 i, resp_valid, resp_error, resp_rdata, mem_byteena, mem_wren);
      end
      next_cycle();
      checks++;
      if (resp_valid !== 1'b0 || resp_error !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse_%0d: got v=%0b e=%0b want 0 0", i, resp_valid, resp_error);
      end
    end
  endtask

  task automatic test_wrap();
    mem[15] = 32'hA1B2C3D4;
    mem[0]  = 32'h11223344;
    issue(1'b0, 32'hFFFFFFFE, 32'h0, 3'b010);
    checks++;
    if (mem_address !== 30'h3FFFFFFF) begin errors++; $display("FAIL wrap_acc0: got %h want 3fffffff", mem_address); end
    next_cycle();
    checks++;
    if (mem_address !== 30'h0) begin errors++; $display("FAIL wrap_acc1: got %h want 0", mem_address); end
    next_cycle();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h3344A1B2) begin
      errors++;
      $display("FAIL wrap_resp: got v=%0b r=%h want 1 3344a1b2", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_reset_mid_store();
    int seen;
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    issue(1'b1, 32'h102, 32'hAABBCCDD, 3'b010);
    next_cycle();
    checks++;
    if (mem_byteena !== 4'b0011 || mem_wren !== 1'b1) begin
      errors++;
      $display("FAIL rmid_acc1: got be=%b w=%0b want 0011 1", mem_byteena, mem_wren);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_wren !== 1'b0) begin errors++; $display("FAIL rmid_wren_gate: got %0b want 0", mem_wren); end
    @(posedge clock);
    #1;
    seen = 0;
    if (resp_valid) seen++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %0b want 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rmid_no_resp: got %0d pulses want 0", seen); end
    checks++;
    if (mem[0] !== 32'hCCDD0000 || mem[1] !== 32'h0) begin
      errors++;
      $display("FAIL rmid_mem: got m0=%h m1=%h want ccdd0000 00000000", mem[0], mem[1]);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset();
    test_store_word();
    test_load_extend();
    test_misaligned_load();
    test_misaligned_store();
    test_illegal();
    test_wrap();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_misaligned.md
Name: lsu_misaligned

Overview:
- Multi-cycle load/store unit that sits between the core's memory stage and the data memory port. That port has combinational read data, byte-enabled synchronous writes and a word address.
- Takes one RV32 load/store request per handshake and handles byte lanes, sign/zero extension and misaligned accesses.
- Misaligned accesses are split into two word accesses, so the memory only ever sees aligned word transactions.

Parameters:
- WORD_ADDR_BITS, default `DATA_BITS-2: width of the memory word address. Word addresses wrap modulo 2**WORD_ADDR_BITS.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1=store, 0=load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  illegal funct3; valid only with resp_valid.
- mem_address  out  WORD_ADDR_BITS  word address to memory.
- mem_byteena  out  4  byte lane enables.
- mem_data  out  32  lane-positioned write data.
- mem_wren  out  1  write enable.
- mem_q  in  32  combinational read data for mem_address.

Behaviour:
- States: IDLE, ACC0, ACC1, DONE. Reset -> IDLE.
- req_ready = (state==IDLE) && !reset. Handshake = req_valid && req_ready.
- On handshake, latch the request and compute:
  - off = addr[1:0]; size = 1/2/4 from funct3[1:0].
  - mask8 = ((1<<size)-1) << off.
  - wdata64 = wdata << 8*off.
  - Then go to ACC0.
- Illegal funct3: loads 011/110/111; stores funct3 >= 011. Go directly to DONE with resp_error=1. No memory access occurs.
- ACC0:
  - Drive mem_address = addr[WORD_ADDR_BITS+1:2], mem_byteena = mask8[3:0], mem_data = wdata64[31:0], mem_wren = write.
  - Load: capture mem_q into q0.
  - Next state is ACC1 if mask8[7:4] != 0, else DONE.
- ACC1:
  - Drive mem_address = ACC0 address + 1 (wraps), mem_byteena = mask8[7:4], mem_data = wdata64[63:32].
  - Load: capture q1. Next state DONE.
- DONE:
  - resp_valid=1 for exactly one cycle.
  - Load: resp_rdata = ({q1,q0} >> 8*off), truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU, LW full).
  - Next state IDLE. No response back-pressure; the consumer must accept.
- Latency, accept edge to resp_valid: aligned or non-crossing accesses 2 cycles; word-crossing accesses 3 cycles; errors 1 cycle.
- mem_byteena=0 and mem_wren=0 outside ACC0/ACC1. mem_address holds its last value and is never X.
- mem_wren is gated by !reset, so no write commits on a reset edge.
- Reset values: resp_valid=0, resp_rdata=0, resp_error=0, mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0.
- Reset mid-operation: abort to IDLE and drop the pending response. A half-completed misaligned store leaves only its first half written.
- Word-address wrap: a word-crossing access at the top word wraps to word 0.

Decomposition:
- funct3 load/store encodings and access-size constants go in the shared constants.sv.
- FSM state typedef is local to the module.
- One combinational sub-module, lsu_lane_align:
  - mask/shift of store data into 64-bit lane space;
  - extraction and extension of load data from {q1,q0}.
  - The FSM stays in lsu_misaligned.

Test Plan:
1. SW 0x100, wdata 0xDEADBEEF -> single ACC0: mem_address 0x40, byteena 1111, mem_data 0xDEADBEEF, mem_wren 1 for 1 cycle; resp_valid 2 cycles after accept.
2. mem[0x40]=0x80FF0102: LB 0x103 -> resp_rdata 0xFFFFFF80; LBU 0x103 -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
3. mem[0x40]=0x33221100, mem[0x41]=0x77665544; LW 0x102 -> byteena 1100 then 0011 on addresses 0x40, 0x41; resp_rdata 0x55443322; resp_valid 3 cycles after accept.
4. SH 0x107, wdata 0x0000ABCD -> ACC0: addr 0x41, byteena 1000, mem_data[31:24]=0xCD. ACC1: addr 0x42, byteena 0001, mem_data[7:0]=0xAB.
5. Load funct3 011 -> no mem_byteena/mem_wren activity; resp_valid 1 cycle after accept with resp_error 1, resp_rdata 0.
6. reset=1 during ACC1 of a misaligned SW -> mem_wren 0 at that edge, no resp_valid; req_ready returns 1 the cycle reset drops; only the ACC0 bytes changed in memory.
